// File: rtl/score_link_tx.sv
// score_link_tx: one-wire UART-style transmitter carrying the local 4-bit score
// to the peer board. Frame: start bit, 8 data bits LSB first ({4'b1010, score}),
// optional odd parity bit, stop bit. A frame is sent after reset, on every score
// change and every REFRESH_CYCLES cycles so a late-connected peer resynchronises.
// Optional feature macro: SCORE_LINK_PARITY_EN (inserts an odd-parity bit).
module score_link_tx #(
  parameter int CLKS_PER_BIT   = 868,
  parameter int REFRESH_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] score,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  localparam logic [CW-1:0] BIT_LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
  localparam logic [RW-1:0] REFRESH_PRE  = RW'(REFRESH_CYCLES - 2);
  localparam logic [3:0]    TAG          = 4'b1010;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd4;
`ifdef SCORE_LINK_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif

  logic [2:0]    state_reg;
  logic [CW-1:0] bit_cnt_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shift_reg;
  logic [3:0]    last_score_reg;
  logic          pending_reg;
  logic [RW-1:0] refresh_cnt_reg;
  logic          tx_reg;
  logic          busy_reg;
`ifdef SCORE_LINK_PARITY_EN
  logic          parity_reg;
`endif

  logic launch;
  logic bit_end;

  assign launch  = (state_reg == IDLE) && pending_reg;
  assign bit_end = (bit_cnt_reg == BIT_LAST);

  assign tx         = tx_reg;
  assign busy       = busy_reg;
  assign frame_done = (state_reg == STOP) && bit_end;

  // Trigger bookkeeping: score-change detection and the periodic resend counter.
  // Pending is raised on the same edge the counter lands on REFRESH_CYCLES-1, so
  // unforced frames start exactly REFRESH_CYCLES cycles apart. A launch both
  // consumes the request and samples the score, so coincident triggers merge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg     <= 1'b1;
      refresh_cnt_reg <= '0;
      last_score_reg  <= '0;
    end else if (launch) begin
      pending_reg     <= 1'b0;
      refresh_cnt_reg <= '0;
      last_score_reg  <= score;
    end else begin
      if (refresh_cnt_reg != REFRESH_LAST) begin
        refresh_cnt_reg <= refresh_cnt_reg + RW'(1);
      end
      if ((score != last_score_reg) || (refresh_cnt_reg == REFRESH_PRE)) begin
        pending_reg <= 1'b1;
      end
    end
  end

  // Frame sequencer: each non-idle state holds the line for one bit time;
  // tx and busy are registered together with the state transitions.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
`ifdef SCORE_LINK_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          bit_cnt_reg <= '0;
          if (launch) begin
            shift_reg  <= {TAG, score};
`ifdef SCORE_LINK_PARITY_EN
            parity_reg <= ~^{TAG, score};
`endif
            state_reg  <= START;
            tx_reg     <= 1'b0;
            busy_reg   <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            bit_cnt_reg <= '0;
            bit_idx_reg <= '0;
            state_reg   <= DATA;
            tx_reg      <= shift_reg[0];
          end else begin
            bit_cnt_reg <= bit_cnt_reg + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt_reg <= '0;
            shift_reg   <= {1'b0, shift_reg[7:1]};
            if (bit_idx_reg == 3'd7) begin
`ifdef SCORE_LINK_PARITY_EN
              state_reg <= PARITY;
              tx_reg    <= parity_reg;
`else
              state_reg <= STOP;
              tx_reg    <= 1'b1;
`endif
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              tx_reg      <= shift_reg[1];
            end
          end else begin
            bit_cnt_reg <= bit_cnt_reg + CW'(1);
          end
        end
`ifdef SCORE_LINK_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            bit_cnt_reg <= '0;
            state_reg   <= STOP;
            tx_reg      <= 1'b1;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + CW'(1);
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            bit_cnt_reg <= '0;
            state_reg   <= IDLE;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + CW'(1);
          end
        end
        default: begin
          state_reg   <= IDLE;
          bit_cnt_reg <= '0;
          tx_reg      <= 1'b1;
          busy_reg    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_link_tx.sv
// tb_score_link_tx: directed bench for score_link_tx (CLKS_PER_BIT=4,
// REFRESH_CYCLES=200). A line monitor decodes every complete frame from tx,
// the stimulus block compares frame timing and content with hand-computed values.
module tb_score_link_tx;

  localparam int CPB = 4;
  localparam int RC  = 200;
`ifdef SCORE_LINK_PARITY_EN
  localparam int NB  = 11;
`else
  localparam int NB  = 10;
`endif
  localparam int FLEN = NB * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] score = 4'h5;
  logic       tx;
  logic       busy;
  logic       frame_done;

  score_link_tx #(
    .CLKS_PER_BIT  (CPB),
    .REFRESH_CYCLES(RC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .score     (score),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // cycle label: number of rising edges seen so far
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         start;
    logic [7:0] data;
    logic       par;
    bit         shape_ok;
  } frame_t;

  frame_t rx_q[$];
  int     fd_q[$];
  int     total = 0;
  int     bad = 0;

  logic   wave [0:FLEN-1];
  bit     rx_active = 1'b0;
  int     rx_start = 0;
  int     rx_pos = 0;
  frame_t mon_f;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic finish_now();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  function automatic int fd_at(input int i);
    if (i < fd_q.size()) return fd_q[i];
    return -1;
  endfunction

  // Line monitor: samples tx on falling edges, records whole frames and frame_done pulses
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (tx === 1'b0) begin
        rx_active = 1'b1;
        rx_start  = cyc;
        wave[0]   = tx;
        rx_pos    = 1;
      end
    end else begin
      wave[rx_pos] = tx;
      rx_pos++;
      if (rx_pos == FLEN) begin
        mon_f.start    = rx_start;
        mon_f.shape_ok = 1'b1;
        for (int b = 0; b < NB; b++)
          for (int j = 0; j < CPB; j++)
            if (wave[b*CPB+j] !== wave[b*CPB]) mon_f.shape_ok = 1'b0;
        if (wave[0] !== 1'b0 || wave[(NB-1)*CPB] !== 1'b1) mon_f.shape_ok = 1'b0;
        for (int i = 0; i < 8; i++) mon_f.data[i] = wave[(1+i)*CPB];
        mon_f.par = wave[9*CPB];
        rx_q.push_back(mon_f);
        $display("frame start=%0d data=0x%02h par=%0b shape_ok=%0b",
                 mon_f.start, mon_f.data, mon_f.par, mon_f.shape_ok);
        rx_active = 1'b0;
      end
    end
    if (reset === 1'b0 && frame_done === 1'b1) fd_q.push_back(cyc);
  end

  task automatic wait_frames(input int n, input int budget);
    int i;
    i = 0;
    while (rx_q.size() < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (rx_q.size() < n) begin
      check_val("frame_timeout", rx_q.size(), n);
      finish_now();
    end
  endtask

  task automatic wait_start(output int s, input int budget);
    int i;
    s = -1;
    i = 0;
    while (s < 0 && i < budget) begin
      @(negedge clk);
      if (tx === 1'b0) s = cyc;
      i++;
    end
    if (s < 0) begin
      check_val("start_timeout", 0, 1);
      finish_now();
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    #200000;
    check_val("watchdog", 0, 1);
    finish_now();
  end

  initial begin
    int k, s, s2, base, fdb;
    reset = 1'b1;
    score = 4'h5;
    repeat (3) @(negedge clk);
    check_val("reset_tx", tx, 1);
    check_val("reset_busy", busy, 0);
    check_val("reset_frame_done", frame_done, 0);

    // first frame right after reset release, score 5 -> 0xA5
    reset = 1'b0;
    k = cyc;
    @(negedge clk);
    check_val("t1_tx_low", tx, 0);
    check_val("t1_busy", busy, 1);
    wait_frames(1, 100);
    check_val("t1_start", rx_q[0].start, k + 1);
    check_val("t1_data", rx_q[0].data, 8'hA5);
    check_val("t1_shape", rx_q[0].shape_ok, 1);
`ifdef SCORE_LINK_PARITY_EN
    check_val("t1_parity", rx_q[0].par, 1);
`endif
    wait_until(k + FLEN + 3);
    check_val("t1_fd_count", fd_q.size(), 1);
    check_val("t1_fd_cycle", fd_at(0), k + FLEN);
    check_val("t1_idle_busy", busy, 0);

    // change to 3, then periodic resend 200 cycles after that launch
    base = rx_q.size();
    score = 4'h3;
    wait_frames(base + 2, 600);
    check_val("t2_data0", rx_q[base].data, 8'hA3);
    check_val("t2_data1", rx_q[base+1].data, 8'hA3);
    check_val("t2_period", rx_q[base+1].start - rx_q[base].start, RC);
    check_val("t2_shape", rx_q[base+1].shape_ok, 1);

    // score 3->7 during data bit 2 of the next refresh frame
    base = rx_q.size();
    fdb = fd_q.size();
    wait_start(s, 400);
    wait_until(s + 12);
    score = 4'h7;
    s2 = s + FLEN + 1;
    wait_until(s2 + 10);
    score = 4'h8;
    wait_until(s2 + 20);
    score = 4'h7;
    wait_frames(base + 3, 300);
    check_val("t3_inflight_data", rx_q[base].data, 8'hA3);
    check_val("t3_inflight_start", rx_q[base].start, s);
    check_val("t3_fd_cycle", fd_at(fdb), s + FLEN - 1);
    check_val("t3_follow_data", rx_q[base+1].data, 8'hA7);
    check_val("t3_follow_start", rx_q[base+1].start, s2);
    check_val("t3_toggle_data", rx_q[base+2].data, 8'hA7);
    check_val("t3_toggle_start", rx_q[base+2].start, s2 + FLEN + 1);
    wait_until(s2 + 2*FLEN + 101);
    check_val("t3_no_extra", rx_q.size(), base + 3);

    // reset during data bit 4, then a fresh frame with score C
    base = rx_q.size();
    score = 4'h9;
    wait_start(s, 50);
    wait_until(s + 21);
    reset = 1'b1;
    @(negedge clk);
    check_val("t4_rst_tx", tx, 1);
    check_val("t4_rst_busy", busy, 0);
    check_val("t4_rst_fd", frame_done, 0);
    score = 4'hC;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    k = cyc;
    fdb = fd_q.size();
    @(negedge clk);
    check_val("t4_tx_low", tx, 0);
    wait_frames(base + 1, 100);
    wait_until(k + FLEN + 2);
    check_val("t4_frames", rx_q.size(), base + 1);
    check_val("t4_start", rx_q[base].start, k + 1);
    check_val("t4_data", rx_q[base].data, 8'hAC);
    check_val("t4_shape", rx_q[base].shape_ok, 1);
    check_val("t4_fd_cycle", fd_at(fdb), k + FLEN);

    // score change in the same cycle as refresh expiry -> one frame
    base = rx_q.size();
    wait_until(k + 199);
    score = 4'hD;
    wait_frames(base + 1, 100);
    check_val("t5_start", rx_q[base].start, k + 201);
    check_val("t5_data", rx_q[base].data, 8'hAD);
    wait_until(k + 201 + FLEN + 100);
    check_val("t5_single", rx_q.size(), base + 1);

`ifdef SCORE_LINK_PARITY_EN
    // parity frame with score 1: 0xA1 has three ones -> parity bit 0
    base = rx_q.size();
    fdb = fd_q.size();
    score = 4'h1;
    wait_start(s, 50);
    wait_frames(base + 1, 100);
    check_val("t6_data", rx_q[base].data, 8'hA1);
    check_val("t6_parity", rx_q[base].par, 0);
    check_val("t6_shape", rx_q[base].shape_ok, 1);
    check_val("t6_fd_cycle", fd_at(fdb), s + 43);
`endif

    finish_now();
  end

endmodule
